multicycle_ctrl: RTL and testbench

- Control FSM that sequences the 32-bit MIPS datapath as a multicycle machine: one shared instruction/data memory, ALU reused for PC increment and branch target.
- Decodes opcode/funct from the instruction register and drives every datapath select and write-enable.
- Handshakes with the unified memory port, stalling on each access until it completes.

---
 rtl/multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS control FSM driving datapath selects and
//               strobes over a shared memory port. Optional illegal-opcode
//               trap enabled by macro MULTICYCLE_CTRL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int START_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam int         c_CW       = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [c_CW-1:0]   r_cnt;
    logic              w_delay_done;
    logic              w_mem_req, w_memwrite, w_irwrite, w_pcwrite, w_branch;
    logic              w_regwrite, w_instr_done, w_trap;
    logic [2:0]        w_funct_alu;

    assign w_delay_done = (START_DELAY == 0) || (r_cnt == c_CW'(START_DELAY - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && !w_delay_done)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_funct_alu = 3'b010;
        case (funct)
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_alu = 3'b010;
        endcase
    end

    always_comb begin
        w_next       = S_FETCH;
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_regwrite   = 1'b0;
        w_instr_done = 1'b0;
        w_trap       = 1'b0;
        iord         = 1'b0;
        pcsrc        = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        alucontrol   = 3'b000;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        case (r_state)
            S_IDLE: w_next = w_delay_done ? S_FETCH : S_IDLE;
            S_FETCH: begin
                w_mem_req  = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                w_irwrite  = mem_ready;
                w_pcwrite  = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        w_next       = S_HALT;
`else
                        // Illegal opcode retires as a NOP
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                w_next     = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                w_next    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req    = 1'b1;
                w_memwrite   = 1'b1;
                iord         = 1'b1;
                w_instr_done = mem_ready;
                w_next       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca      = 1'b1;
                alucontrol   = 3'b110;
                w_branch     = 1'b1;
                pcsrc        = 2'b01;
                w_instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                w_next     = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc        = 2'b10;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_HALT: begin
                w_trap = 1'b1;
                w_next = S_HALT;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an abandoned access never writes
    assign mem_req    = w_mem_req    & reset;
    assign memwrite   = w_memwrite   & reset;
    assign irwrite    = w_irwrite    & reset;
    assign pcwrite    = w_pcwrite    & reset;
    assign branch     = w_branch     & reset;
    assign regwrite   = w_regwrite   & reset;
    assign instr_done = w_instr_done & reset;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap       = w_trap       & reset;
`else
    assign trap       = 1'b0;
    logic w_unused;
    assign w_unused   = w_trap;
`endif
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl (START_DELAY=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst, memtoreg, regwrite, instr_done, trap;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.START_DELAY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .instr_done (instr_done),
        .trap       (trap),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {mem_req,memwrite,iord,irwrite,pcwrite,branch} pcsrc alusrca alusrcb
    // alucontrol {regdst,memtoreg,regwrite,instr_done,trap} state
    logic [22:0] obs;
    assign obs = {mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc, alusrca,
                  alusrcb, alucontrol, regdst, memtoreg, regwrite, instr_done, trap, state};

    logic [7:0] strobes;
    assign strobes = {mem_req, memwrite, irwrite, pcwrite, branch, regwrite, instr_done, trap};

    function automatic logic [22:0] v(input logic [5:0] s, input logic [1:0] pcs,
                                      input logic a, input logic [1:0] b, input logic [2:0] alu,
                                      input logic [4:0] wb, input logic [3:0] st);
        return {s, pcs, a, b, alu, wb, st};
    endfunction

    function automatic logic [22:0] e_idle();      return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b0, 4'd0); endfunction
    function automatic logic [22:0] e_fetch(input logic r);
        return v({1'b1, 1'b0, 1'b0, r, r, 1'b0}, 2'b00, 1'b0, 2'b01, 3'b010, 5'b0, 4'd1);
    endfunction
    function automatic logic [22:0] e_fetch_rst(); return v(6'b0, 2'b00, 1'b0, 2'b01, 3'b010, 5'b0, 4'd1); endfunction
    function automatic logic [22:0] e_dec();       return v(6'b0, 2'b00, 1'b0, 2'b11, 3'b010, 5'b0, 4'd2); endfunction
    function automatic logic [22:0] e_dec_nop();   return v(6'b0, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00010, 4'd2); endfunction
    function automatic logic [22:0] e_memadr();    return v(6'b0, 2'b00, 1'b1, 2'b10, 3'b010, 5'b0, 4'd3); endfunction
    function automatic logic [22:0] e_memrd();     return v(6'b101000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b0, 4'd4); endfunction
    function automatic logic [22:0] e_memwb();     return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b01110, 4'd5); endfunction
    function automatic logic [22:0] e_memwr(input logic r);
        return v(6'b111000, 2'b00, 1'b0, 2'b00, 3'b000, {3'b000, r, 1'b0}, 4'd6);
    endfunction
    function automatic logic [22:0] e_memwr_rst(); return v(6'b001000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b0, 4'd6); endfunction
    function automatic logic [22:0] e_exec(input logic [2:0] a);
        return v(6'b0, 2'b00, 1'b1, 2'b00, a, 5'b0, 4'd7);
    endfunction
    function automatic logic [22:0] e_aluwb();     return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10110, 4'd8); endfunction
    function automatic logic [22:0] e_branch();    return v(6'b000001, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010, 4'd9); endfunction
    function automatic logic [22:0] e_addiex();    return v(6'b0, 2'b00, 1'b1, 2'b10, 3'b010, 5'b0, 4'd10); endfunction
    function automatic logic [22:0] e_addiwb();    return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00110, 4'd11); endfunction
    function automatic logic [22:0] e_jump();      return v(6'b000010, 2'b10, 1'b0, 2'b00, 3'b000, 5'b00010, 4'd12); endfunction
    function automatic logic [22:0] e_halt();      return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00001, 4'd13); endfunction
    function automatic logic [22:0] e_halt_rst();  return v(6'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b0, 4'd13); endfunction

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; op = 6'b100011; funct = 6'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (strobes !== 8'h00) begin
                failures++;
                $display("FAIL reset_strobes[%0d] got=%h exp=00", i, strobes);
            end
            @(posedge clk); #1;
        end
        begin
            logic [22:0] et [3];
            et = '{e_idle(), e_idle(), e_fetch(1'b0)};
            reset = 1'b1; mem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (obs !== et[i]) begin
                    failures++;
                    $display("FAIL startup[%0d] got=%h exp=%h", i, obs, et[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lw();
        logic [22:0] et [12];
        logic        rt [12];
        int          n;
        op = 6'b100011;
        et = '{e_fetch(1'b1), e_dec(), e_memadr(), e_memrd(), e_memwb(),
               e_fetch(1'b0), e_fetch(1'b1), e_dec(), e_memadr(), e_memrd(), e_memrd(), e_memwb()};
        rt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        n  = 12;
        for (int i = 0; i < n; i++) begin
            mem_ready = rt[i];
            #1;
            checks++;
            if (obs !== et[i]) begin
                failures++;
                $display("FAIL lw[%0d] got=%h exp=%h", i, obs, et[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        logic [22:0] et [7];
        logic        rt [7];
        op = 6'b101011;
        et = '{e_fetch(1'b1), e_dec(), e_memadr(), e_memwr(1'b0), e_memwr(1'b0),
               e_memwr(1'b0), e_memwr(1'b1)};
        rt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rt[i];
            #1;
            checks++;
            if (obs !== et[i]) begin
                failures++;
                $display("FAIL sw[%0d] got=%h exp=%h", i, obs, et[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [6];
        logic [2:0]  al [6];
        logic [22:0] et [4];
        fn = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        al = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111,    3'b010};
        op = 6'b000000; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            et = '{e_fetch(1'b1), e_dec(), e_exec(al[k]), e_aluwb()};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (obs !== et[i]) begin
                    failures++;
                    $display("FAIL rtype_f%b[%0d] got=%h exp=%h", fn[k], i, obs, et[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch_jump_addi();
        logic [5:0]  ops [3];
        logic [22:0] et  [3][5];
        int          len [3];
        ops = '{6'b000100, 6'b000010, 6'b001000};
        et[0] = '{e_fetch(1'b1), e_dec(), e_branch(), e_fetch(1'b0), e_fetch(1'b0)};
        et[1] = '{e_fetch(1'b1), e_dec(), e_jump(),   e_fetch(1'b0), e_fetch(1'b0)};
        et[2] = '{e_fetch(1'b1), e_dec(), e_addiex(), e_addiwb(),    e_fetch(1'b0)};
        len = '{4, 4, 5};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            for (int i = 0; i < len[k]; i++) begin
                mem_ready = (i < len[k] - 1);
                #1;
                checks++;
                if (obs !== et[k][i]) begin
                    failures++;
                    $display("FAIL ctl_op%b[%0d] got=%h exp=%h", ops[k], i, obs, et[k][i]);
                end
                if (i < len[k] - 1) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_reset_midaccess();
        logic [22:0] et [15];
        logic        rt [15];
        logic        rs [15];
        et = '{e_fetch(1'b0), e_fetch_rst(), e_idle(), e_idle(), e_idle(), e_fetch(1'b1),
               e_dec(), e_memadr(), e_memwr(1'b0), e_memwr_rst(), e_idle(), e_idle(), e_idle(),
               e_fetch(1'b0), e_fetch(1'b0)};
        rt = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0};
        rs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1};
        op = 6'b101011;
        for (int i = 0; i < 15; i++) begin
            reset = rs[i]; mem_ready = rt[i];
            #1;
            checks++;
            if (obs !== et[i]) begin
                failures++;
                $display("FAIL rst_mid[%0d] got=%h exp=%h", i, obs, et[i]);
            end
            if (i < 14) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        logic [22:0] et [10];
        logic        rs [10];
        int          n;
        et = '{e_fetch(1'b1), e_dec(), e_halt(), e_halt(), e_halt(), e_halt_rst(),
               e_idle(), e_idle(), e_idle(), e_fetch(1'b0)};
        rs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n  = 10;
`else
        logic [22:0] et [3];
        logic        rs [3];
        int          n;
        et = '{e_fetch(1'b1), e_dec_nop(), e_fetch(1'b0)};
        rs = '{1'b1, 1'b1, 1'b1};
        n  = 3;
`endif
        op = 6'b111111;
        for (int i = 0; i < n; i++) begin
            reset = rs[i];
            mem_ready = (i == 0) || (et[i] == e_halt());
            #1;
            checks++;
            if (obs !== et[i]) begin
                failures++;
                $display("FAIL illegal[%0d] got=%h exp=%h", i, obs, et[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch_jump_addi();
        test_reset_midaccess();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
